// File: rtl/mul2x2_seq_ctrl.sv
// Sequencer that builds a 4x4 unsigned product from four passes through an
// external 2x2 multiplier core, shift-accumulating and counting inexact core outputs.
module mul2x2_seq_ctrl #(
  parameter int ERR_W  = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       res,
  output logic             res_sat,
  output logic             res_err,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic [1:0]       core_a,
  output logic [1:0]       core_b,
  input  logic [3:0]       core_p
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] step;
  logic [3:0] a_q, b_q;
  logic [8:0] acc, acc_nxt, addend;
  logic       err_q;
  logic [3:0] exact;
  logic       mis;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_a    = 2'd0;
    core_b    = 2'd0;
    addend    = 9'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        // step[0] selects the high half of a, step[1] the high half of b
        core_a = step[0] ? a_q[3:2] : a_q[1:0];
        core_b = step[1] ? b_q[3:2] : b_q[1:0];
        case (step)
          2'd0:    addend = {5'd0, core_p};
          2'd3:    addend = {1'b0, core_p, 4'd0};
          default: addend = {3'd0, core_p, 2'd0};
        endcase
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign exact   = {2'd0, core_a} * {2'd0, core_b};
  assign mis     = (state == RUN) && (core_p != exact);
  assign acc_nxt = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= 2'd0;
      acc     <= 9'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      err_q   <= 1'b0;
      res     <= 8'd0;
      res_sat <= 1'b0;
      res_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          acc   <= 9'd0;
          err_q <= 1'b0;
          step  <= 2'd0;
        end
        RUN: begin
          acc   <= acc_nxt;
          err_q <= err_q | mis;
          step  <= step + 2'd1;
          if (step == 2'd3) begin
            res     <= (SAT_EN && acc_nxt[8]) ? 8'hFF : acc_nxt[7:0];
            res_sat <= acc_nxt[8];
            res_err <= err_q | mis;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear wins over a same-cycle mismatch; count sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || err_clr)
      err_cnt <= '0;
    else if (mis && (err_cnt != {ERR_W{1'b1}}))
      err_cnt <= err_cnt + ERR_W'(1);
  end

endmodule

// File: tb/tb_mul2x2_seq_ctrl.sv
// Directed bench: three lockstep instances (saturating, wrapping, 2-bit error
// counter) sharing one requester, each with a selectable stub core.
module tb_mul2x2_seq_ctrl;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, err_clr;
  logic [3:0] a, b;
  int   mode; // 0 exact core, 1 constant 0, 2 constant 15

  logic       ir0, ov0, rs0, re0; logic [7:0] r0; logic [7:0] ec0;
  logic [1:0] ca0, cb0; logic [3:0] p0;
  logic       ir1, ov1, rs1, re1; logic [7:0] r1; logic [7:0] ec1;
  logic [1:0] ca1, cb1; logic [3:0] p1;
  logic       ir2, ov2, rs2, re2; logic [7:0] r2; logic [1:0] ec2;
  logic [1:0] ca2, cb2; logic [3:0] p2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always_comb begin
    p0 = (mode == 0) ? {2'd0, ca0} * {2'd0, cb0} : (mode == 1) ? 4'd0 : 4'd15;
    p1 = (mode == 0) ? {2'd0, ca1} * {2'd0, cb1} : (mode == 1) ? 4'd0 : 4'd15;
    p2 = (mode == 0) ? {2'd0, ca2} * {2'd0, cb2} : (mode == 1) ? 4'd0 : 4'd15;
  end

  mul2x2_seq_ctrl #(.ERR_W(8), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .res(r0), .res_sat(rs0), .res_err(re0),
    .err_cnt(ec0), .err_clr(err_clr), .core_a(ca0), .core_b(cb0), .core_p(p0));

  mul2x2_seq_ctrl #(.ERR_W(8), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .res(r1), .res_sat(rs1), .res_err(re1),
    .err_cnt(ec1), .err_clr(err_clr), .core_a(ca1), .core_b(cb1), .core_p(p1));

  mul2x2_seq_ctrl #(.ERR_W(2), .SAT_EN(1'b1)) dut_e2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
    .out_valid(ov2), .out_ready(out_ready), .res(r2), .res_sat(rs2), .res_err(re2),
    .err_cnt(ec2), .err_clr(err_clr), .core_a(ca2), .core_b(cb2), .core_p(p2));

  // Present operands and return at the negedge just after the accept edge
  task automatic start_op(input logic [3:0] ta, input logic [3:0] tb);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir0 && n < 30) begin @(negedge clk); n++; end
    nvec++;
    if (ir0 !== 1'b1) begin nerr++; $display("FAIL start_ready: in_ready=%b want 1", ir0); end
    in_valid = 1'b1; a = ta; b = tb;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid; accept->valid should take 4 more cycles
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!ov0 && n < 20) begin
      nvec++;
      if (ir0 !== 1'b0) begin nerr++; $display("FAIL %s busy_ready: in_ready=%b want 0", nm, ir0); end
      @(negedge clk); n++;
    end
    nvec++;
    if (n !== 4) begin nerr++; $display("FAIL %s latency: got %0d want 4", nm, n); end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; a = 4'd0; b = 4'd0; mode = 0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({ir0, ov0, r0, rs0, re0, ec0, ca0, cb0} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2'd0, 2'd0}) begin
      nerr++; $display("FAIL reset: ir=%b ov=%b res=%0d sat=%b err=%b cnt=%0d ca=%0d cb=%0d want 1 0 0 0 0 0 0 0",
                       ir0, ov0, r0, rs0, re0, ec0, ca0, cb0);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact;
    mode = 0;
    start_op(4'hF, 4'hF);
    wait_done("exact");
    nvec++;
    if ({r0, rs0, re0, ec0} !== {8'd225, 1'b0, 1'b0, 8'd0}) begin
      nerr++; $display("FAIL exact_ff: res=%0d sat=%b err=%b cnt=%0d want 225 0 0 0", r0, rs0, re0, ec0);
    end
    @(negedge clk);
    nvec++;
    if ({ov0, ir0} !== 2'b01) begin nerr++; $display("FAIL exact_release: ov=%b ir=%b want 0 1", ov0, ir0); end
  endtask

  task automatic test_zero_core;
    mode = 1;
    start_op(4'd5, 4'd5);
    wait_done("zero1");
    nvec++;
    if ({r0, re0, ec0, ec2} !== {8'd0, 1'b1, 8'd4, 2'd3}) begin
      nerr++; $display("FAIL zero_core1: res=%0d err=%b cnt=%0d cnt2=%0d want 0 1 4 3", r0, re0, ec0, ec2);
    end
    start_op(4'd5, 4'd5);
    wait_done("zero2");
    nvec++;
    if ({ec0, ec2} !== {8'd8, 2'd3}) begin
      nerr++; $display("FAIL zero_core2: cnt=%0d cnt2=%0d want 8 3", ec0, ec2);
    end
  endtask

  task automatic test_overflow;
    mode = 2;
    start_op(4'd5, 4'd5);
    wait_done("ovf");
    nvec++;
    if ({r0, rs0} !== {8'd255, 1'b1}) begin nerr++; $display("FAIL ovf_sat: res=%0d sat=%b want 255 1", r0, rs0); end
    nvec++;
    if ({r1, rs1} !== {8'd119, 1'b1}) begin nerr++; $display("FAIL ovf_wrap: res=%0d sat=%b want 119 1", r1, rs1); end
    nvec++;
    if (ec0 !== 8'd12) begin nerr++; $display("FAIL ovf_cnt: cnt=%0d want 12", ec0); end
  endtask

  task automatic test_err_clr;
    mode = 1;
    start_op(4'd5, 4'd5);   // now in the first RUN cycle, a mismatch cycle
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    nvec++;
    if ({ec0, ec2} !== {8'd0, 2'd0}) begin nerr++; $display("FAIL clr_edge: cnt=%0d cnt2=%0d want 0 0", ec0, ec2); end
    while (!ov0) @(negedge clk);
    nvec++;
    if ({ec0, ec2, re0} !== {8'd3, 2'd3, 1'b1}) begin
      nerr++; $display("FAIL clr_after: cnt=%0d cnt2=%0d err=%b want 3 3 1", ec0, ec2, re0);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    mode = 0;
    out_ready = 1'b0;
    start_op(4'd7, 4'd9);
    wait_done("bp");
    in_valid = 1'b1; a = 4'd1; b = 4'd1;
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if ({ov0, ir0, r0, re0} !== {1'b1, 1'b0, 8'd63, 1'b0}) begin
        nerr++; $display("FAIL bp_hold[%0d]: ov=%b ir=%b res=%0d err=%b want 1 0 63 0", i, ov0, ir0, r0, re0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if ({ov0, ir0, ec0} !== {1'b0, 1'b1, 8'd3}) begin
      nerr++; $display("FAIL bp_release: ov=%b ir=%b cnt=%0d want 0 1 3", ov0, ir0, ec0);
    end
  endtask

  task automatic test_mid_reset;
    mode = 0;
    start_op(4'hF, 4'hF);   // cycle T+1
    @(negedge clk);         // cycle T+2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({ir0, ov0, r0, rs0, re0, ec0, ca0, cb0} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 2'd0, 2'd0}) begin
      nerr++; $display("FAIL midrst: ir=%b ov=%b res=%0d sat=%b err=%b cnt=%0d ca=%0d cb=%0d want 1 0 0 0 0 0 0 0",
                       ir0, ov0, r0, rs0, re0, ec0, ca0, cb0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nvec++;
      if (ov0 !== 1'b0) begin nerr++; $display("FAIL midrst_noresult[%0d]: ov=%b want 0", i, ov0); end
    end
    start_op(4'd3, 4'd2);
    wait_done("post");
    nvec++;
    if ({r0, re0} !== {8'd6, 1'b0}) begin nerr++; $display("FAIL post_rst_op: res=%0d err=%b want 6 0", r0, re0); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_exact;
    test_zero_core;
    test_overflow;
    test_err_clr;
    test_backpressure;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul2x2_seq_ctrl.md
Name: mul2x2_seq_ctrl

Overview:
- Sequencer that builds an unsigned 4x4 -> 8-bit product from four passes through one shared 2x2 multiplier core. The core is the combinational, 4-in/4-out approximate multiplier netlist.
- Handles the operand handshake, schedules the partial products and shift-accumulates them.
- Counts core outputs that differ from the exact 2x2 product, so the approximation error is visible at run time.
- Sits between the requester and a single core instance; the core is instantiated outside this block.

Parameters:
- ERR_W, 8, width of the saturating mismatch counter.
- SAT_EN, 1, 1: result saturates at 255 on overflow; 0: result wraps modulo 256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  4  multiplicand, unsigned.
- b  in  4  multiplier, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- res  out  8  product.
- res_sat  out  1  accumulated sum exceeded 255.
- res_err  out  1  at least one of the four core products was inexact.
- err_cnt  out  ERR_W  total inexact core products since reset or clear; saturating.
- err_clr  in  1  clears err_cnt.
- core_a  out  2  to core in1:in0 (in0 = LSB).
- core_b  out  2  to core in3:in2 (in2 = LSB).
- core_p  in  4  from core out3..out0 (out0 = LSB); combinational, valid in the same cycle.

Behaviour:
- Reset, synchronous, takes priority over everything:
  - state=IDLE, step=0, acc=0.
  - in_ready=1, out_valid=0, res=0, res_sat=0, res_err=0, err_cnt=0, core_a=core_b=0.
  - Reset during RUN or DONE aborts the operation; no result is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch a and b, clear acc and the error flag, set step=0, go to RUN.
- RUN lasts exactly 4 cycles with in_ready=0. Step schedule (operand pair, shift):
  - step 0: a[1:0] x b[1:0], shift 0.
  - step 1: a[3:2] x b[1:0], shift 2.
  - step 2: a[1:0] x b[3:2], shift 2.
  - step 3: a[3:2] x b[3:2], shift 4.
- Per RUN cycle:
  - core_a and core_b are driven from the latched operands selected by the registered step.
  - acc (9 bits) += core_p << shift at the edge.
  - The internal exact product of the same pair is compared with core_p; a mismatch sets the error flag and increments err_cnt.
  - After step 3, go to DONE.
- core_a and core_b are 0 in IDLE and DONE.
- Accumulation: max approximate sum is 15+60+60+240 = 375, so acc is 9 bits wide. res_sat = acc[8].
  - SAT_EN=1: res = 255 when acc[8]=1, else acc[7:0].
  - SAT_EN=0: res = acc[7:0].
- DONE:
  - out_valid=1; res, res_sat and res_err stay stable until out_ready=1.
  - The handshake edge returns to IDLE and clears out_valid.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Timing: accept edge T; RUN during cycles T+1..T+4; out_valid=1 from cycle T+5. Minimum spacing between accepts is 6 cycles.
- res, res_sat and res_err are registered and are only updated on the RUN-to-DONE transition.
- err_cnt:
  - Increments by 1 per mismatching RUN cycle.
  - Holds at 2^ERR_W-1 once it reaches that value.
  - err_clr has priority: if err_clr and a mismatch fall in the same cycle, err_cnt becomes 0 and that mismatch is not counted.
  - err_clr does not affect res_err.
- in_valid while busy is ignored; the requester holds it until in_ready is high.

Test Plan:
- Exact stub core; a=4'hF, b=4'hF, out_ready=1 -> in_ready low for 5 cycles; out_valid at T+5 with res=225, res_sat=0, res_err=0, err_cnt=0.
- Stub core returning constant 0; a=5, b=5 (all pairs 01x01) -> res=0, res_err=1, err_cnt=4. Repeat the operation -> err_cnt=8.
- Stub core returning constant 15, SAT_EN=1 -> acc=375, res=255, res_sat=1. With SAT_EN=0 -> res=119, res_sat=1.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> res stable, in_ready=0, a second in_valid is ignored. Raising out_ready -> out_valid drops next cycle and in_ready=1.
- Mid-operation reset: assert rst at T+2 -> next cycle all outputs at reset values and no out_valid. A new operation a=3, b=2 with exact core -> res=6 at its T+5.
- ERR_W=2 with the constant-0 core and a=5, b=5 -> err_cnt saturates at 3. err_clr asserted on a mismatch cycle -> err_cnt=0 after that edge.
